fetch_queue: RTL

Parametrised multi-issue instruction buffer between fetch and decode in the out-of-order datapath. It decouples instruction-side `i_data_ok` stalls from decode and renaming by absorbing up to `FETCH_WIDTH` fetched instructions per cycle and presenting up to `ISSUE_WIDTH` in program order. It is a circular buffer with lane compaction and a flush on pipeline redirect. It replaces the single-entry fetch-to-decode register path.

---
 rtl/common.sv | 16 +
 rtl/fetch_queue_compact.sv | 27 ++
 rtl/fetch_queue.sv | 89 ++++++++
 3 files changed

// File: rtl/common.sv
// Shared front-end types: instruction word, fetch-queue entry and datapath widths.
package common;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t pc;
        word_t instr;
        logic  fault;
    } fetch_entry_t;

    localparam int FETCH_WIDTH = 2;
    localparam int ISSUE_WIDTH = 2;
    localparam int FQ_DEPTH    = 8;

endpackage

// File: rtl/fetch_queue_compact.sv
// Lane compaction for the fetch queue: per-lane slot offset (prefix popcount) and write enables.
module fetch_queue_compact #(
    parameter int FETCH_WIDTH = 2,
    parameter int OFF_W       = $clog2(FETCH_WIDTH + 1)
) (
    input  logic                                en,
    input  logic [FETCH_WIDTH-1:0]              in_valid,
    output logic [FETCH_WIDTH-1:0]              wr_en,
    output logic [FETCH_WIDTH-1:0][OFF_W-1:0]   offset,
    output logic [OFF_W-1:0]                    num
);

    logic [OFF_W-1:0] acc;

    always_comb begin
        acc    = '0;
        wr_en  = '0;
        offset = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            offset[i] = acc;
            wr_en[i]  = en & in_valid[i];
            acc       = acc + OFF_W'(in_valid[i]);
        end
        num = en ? acc : '0;
    end

endmodule

// File: rtl/fetch_queue.sv
// Multi-issue circular instruction buffer between fetch and decode, with lane compaction and flush.
module fetch_queue
    import common::fetch_entry_t;
#(
    parameter int FETCH_WIDTH = common::FETCH_WIDTH,
    parameter int ISSUE_WIDTH = common::ISSUE_WIDTH,
    parameter int DEPTH       = common::FQ_DEPTH,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int CNT_W      = PTR_W + 1,
    localparam int DEQ_W      = $clog2(ISSUE_WIDTH + 1)
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             flush,
    input  logic [FETCH_WIDTH-1:0]           in_valid,
    input  fetch_entry_t [FETCH_WIDTH-1:0]   in_entry,
    output logic                             in_ready,
    output logic [ISSUE_WIDTH-1:0]           out_valid,
    output fetch_entry_t [ISSUE_WIDTH-1:0]   out_entry,
    input  logic [DEQ_W-1:0]                 deq_num,
    output logic [CNT_W-1:0]                 count
);

    localparam int OFF_W = $clog2(FETCH_WIDTH + 1);

    logic [PTR_W-1:0]                    head;
    logic [PTR_W-1:0]                    tail;
    fetch_entry_t                        mem [DEPTH];
    logic                                enq;
    logic [FETCH_WIDTH-1:0]              wr_en;
    logic [FETCH_WIDTH-1:0][OFF_W-1:0]   offset;
    logic [OFF_W-1:0]                    enq_num;
    logic [CNT_W-1:0]                    deq_req;
    logic [CNT_W-1:0]                    deq_eff;

    // Ready depends on registered occupancy only, so a same-cycle pop never frees space for a push.
    assign in_ready = (count <= CNT_W'(DEPTH - FETCH_WIDTH));
    assign enq      = in_ready & ~flush;

    fetch_queue_compact #(
        .FETCH_WIDTH (FETCH_WIDTH),
        .OFF_W       (OFF_W)
    ) u_compact (
        .en       (enq),
        .in_valid (in_valid),
        .wr_en    (wr_en),
        .offset   (offset),
        .num      (enq_num)
    );

    // Over-requests from decode are clipped to the current occupancy.
    assign deq_req = CNT_W'(deq_num);
    assign deq_eff = (deq_req > count) ? count : deq_req;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(deq_eff);
            tail  <= tail + PTR_W'(enq_num);
            count <= count + CNT_W'(enq_num) - deq_eff;
        end
    end

    // Storage is data-only: no reset, and flush leaves the contents in place.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (wr_en[i]) begin
                mem[tail + PTR_W'(offset[i])] <= in_entry[i];
            end
        end
    end

    always_comb begin
        out_valid = '0;
        out_entry = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            out_valid[i] = (count > CNT_W'(i));
            out_entry[i] = mem[head + PTR_W'(i)];
        end
    end

endmodule
